// File: rtl/fb_swap_arbiter.sv
// Double-buffered frame-buffer controller: arbitrates one single-port RAM between display
// reads (highest priority), rasterizer pixel writes and back-buffer clears; swaps in vblank.
module fb_swap_arbiter #(
    parameter int unsigned           H_RES       = 640,
    parameter int unsigned           V_RES       = 480,
    parameter int unsigned           ADDR_W      = 20,
    parameter int unsigned           COLOR_W     = 3,
    parameter int unsigned           CLEAR_EN    = 1,
    parameter logic [COLOR_W-1:0]    CLEAR_COLOR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rast_pixel_rdy,
    input  logic [9:0]         rast_width,
    input  logic [8:0]         rast_height,
    input  logic [COLOR_W-1:0] rast_color_input,
    output logic               read_rast_pixel_rdy,
    input  logic               rast_done,
    input  logic               disp_req,
    input  logic [9:0]         disp_x,
    input  logic [8:0]         disp_y,
    input  logic               disp_vblank,
    output logic [COLOR_W-1:0] disp_data,
    output logic               disp_data_vld,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic               front_buf,
    output logic               frame_swapped
);
    localparam int unsigned OFF_W = ADDR_W - 1;
    localparam logic [OFF_W-1:0] CLR_LAST = OFF_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {S_DRAW, S_WAIT_SWAP, S_SWAP, S_CLEAR} state_t;

    state_t             r_state, w_next;
    logic [OFF_W-1:0]   r_clr_cnt;
    logic               r_front;
    logic               r_rd_vld;
    logic               r_data_vld;
    logic               r_swapped;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic [COLOR_W-1:0] r_wdata;

    logic [OFF_W-1:0]   w_pix_off, w_disp_off;
    logic               w_in_range, w_accept;

    assign w_pix_off  = OFF_W'(rast_height) * OFF_W'(H_RES) + OFF_W'(rast_width);
    assign w_disp_off = OFF_W'(disp_y) * OFF_W'(H_RES) + OFF_W'(disp_x);
    assign w_in_range = (32'(rast_width) < H_RES) && (32'(rast_height) < V_RES);
    assign w_accept   = rast_pixel_rdy & ~disp_req & (r_state == S_DRAW) & ~rst;

    assign read_rast_pixel_rdy = w_accept;
    assign disp_data           = mem_rdata;
    assign disp_data_vld       = r_data_vld;
    assign mem_addr            = r_addr;
    assign mem_we              = r_we;
    assign mem_wdata           = r_wdata;
    assign front_buf           = r_front;
    assign frame_swapped       = r_swapped;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_DRAW:      if (rast_done) w_next = S_WAIT_SWAP;
            S_WAIT_SWAP: if (disp_vblank) w_next = S_SWAP;
            S_SWAP:      w_next = (CLEAR_EN != 0) ? S_CLEAR : S_DRAW;
            S_CLEAR:     if (!disp_req && r_clr_cnt == CLR_LAST) w_next = S_DRAW;
            default:     w_next = S_DRAW;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_DRAW;
        else
            r_state <= w_next;
    end

    // Reads address the buffer selected at request time, so a read just before a swap
    // still returns old-front data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt  <= '0;
            r_front    <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_data_vld <= 1'b0;
            r_swapped  <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_rd_vld   <= disp_req;
            r_data_vld <= r_rd_vld;
            r_swapped  <= (r_state == S_SWAP);
            if (r_state == S_SWAP)
                r_front <= ~r_front;
            r_we <= 1'b0;
            if (disp_req) begin
                r_addr <= {r_front, w_disp_off};
            end else if (w_accept) begin
                // Out-of-range pixels are handshaken but dropped.
                if (w_in_range) begin
                    r_we    <= 1'b1;
                    r_addr  <= {~r_front, w_pix_off};
                    r_wdata <= rast_color_input;
                end
            end else if (r_state == S_CLEAR) begin
                r_we      <= 1'b1;
                r_addr    <= {~r_front, r_clr_cnt};
                r_wdata   <= CLEAR_COLOR;
                r_clr_cnt <= (r_clr_cnt == CLR_LAST) ? '0 : r_clr_cnt + OFF_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fb_swap_arbiter.sv
// Directed bench: full-size instance for handshake/read/swap/reset checks, small-frame
// instance to exercise a complete back-buffer clear.
module tb_fb_swap_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [9:0]  x, dx;
    logic [8:0]  y, dy;
    logic [2:0]  col;

    logic        rdy, done, req, vb;
    logic [2:0]  rdata;
    logic        m_rrdy, m_dvld, m_we, m_front, m_fs;
    logic [2:0]  m_ddata, m_wdata;
    logic [19:0] m_addr;

    logic        s_rdy, s_done, s_req, s_vb;
    logic [2:0]  s_rdata = 3'd0;
    logic        s_rrdy, s_dvld, s_we, s_front, s_fs;
    logic [2:0]  s_ddata, s_wdata;
    logic [19:0] s_addr;

    int n_cmp = 0;
    int n_err = 0;
    int w, bad, acc;

    fb_swap_arbiter u_dut (
        .clk(clk), .rst(rst),
        .rast_pixel_rdy(rdy), .rast_width(x), .rast_height(y), .rast_color_input(col),
        .read_rast_pixel_rdy(m_rrdy), .rast_done(done),
        .disp_req(req), .disp_x(dx), .disp_y(dy), .disp_vblank(vb),
        .disp_data(m_ddata), .disp_data_vld(m_dvld),
        .mem_addr(m_addr), .mem_we(m_we), .mem_wdata(m_wdata), .mem_rdata(rdata),
        .front_buf(m_front), .frame_swapped(m_fs)
    );

    fb_swap_arbiter #(.H_RES(8), .V_RES(4)) u_small (
        .clk(clk), .rst(rst),
        .rast_pixel_rdy(s_rdy), .rast_width(x), .rast_height(y), .rast_color_input(col),
        .read_rast_pixel_rdy(s_rrdy), .rast_done(s_done),
        .disp_req(s_req), .disp_x(dx), .disp_y(dy), .disp_vblank(s_vb),
        .disp_data(s_ddata), .disp_data_vld(s_dvld),
        .mem_addr(s_addr), .mem_we(s_we), .mem_wdata(s_wdata), .mem_rdata(s_rdata),
        .front_buf(s_front), .frame_swapped(s_fs)
    );

    // RAM model: one-cycle read latency, data is a fixed function of the address.
    always @(posedge clk) rdata <= m_addr[2:0] ^ 3'd5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; done = 1'b0; req = 1'b0; vb = 1'b0;
        s_rdy = 1'b0; s_done = 1'b0; s_req = 1'b0; s_vb = 1'b0;
        x = '0; y = '0; dx = '0; dy = '0; col = '0;
        #12;
        chk("rst_rrdy", 32'(m_rrdy), 0);
        chk("rst_we", 32'(m_we), 0);
        chk("rst_addr", 32'(m_addr), 0);
        chk("rst_dvld", 32'(m_dvld), 0);
        chk("rst_front", 32'(m_front), 0);
        chk("rst_fs", 32'(m_fs), 0);
        rdy = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick;

        // pixel write into back buffer 1
        x = 10'd5; y = 9'd2; col = 3'd5; rdy = 1'b1;
        #1 chk("t1_accept", 32'(m_rrdy), 1);
        tick;
        chk("t1_we", 32'(m_we), 1);
        chk("t1_addr", 32'(m_addr), 32'h80505);
        chk("t1_wdata", 32'(m_wdata), 5);
        rdy = 1'b0;

        // display read beats a pending pixel
        rdy = 1'b1; req = 1'b1; dx = 10'd0; dy = 9'd1;
        #1 chk("t2_no_accept", 32'(m_rrdy), 0);
        tick;
        chk("t2_addr", 32'(m_addr), 640);
        chk("t2_we", 32'(m_we), 0);
        chk("t2_vld_early", 32'(m_dvld), 0);
        req = 1'b0; rdy = 1'b0;
        tick;
        chk("t2_vld", 32'(m_dvld), 1);
        chk("t2_data", 32'(m_ddata), 5);
        tick;
        chk("t2_vld_end", 32'(m_dvld), 0);

        // out-of-range pixels are accepted but never written
        rdy = 1'b1; x = 10'd640; y = 9'd0;
        #1 chk("t5a_accept", 32'(m_rrdy), 1);
        tick;
        chk("t5a_we", 32'(m_we), 0);
        x = 10'd0; y = 9'd480;
        #1 chk("t5b_accept", 32'(m_rrdy), 1);
        tick;
        chk("t5b_we", 32'(m_we), 0);
        chk("t5_addr_hold", 32'(m_addr), 640);
        rdy = 1'b0;

        // swap request waits for vblank
        done = 1'b1;
        tick;
        done = 1'b0; rdy = 1'b1; x = 10'd5; y = 9'd2; acc = 0;
        repeat (100) begin
            if (m_rrdy || m_we) acc++;
            tick;
        end
        chk("t3_no_accept", 32'(acc), 0);
        vb = 1'b1;
        tick;
        chk("t3_front_pre", 32'(m_front), 0);
        chk("t3_fs_pre", 32'(m_fs), 0);
        vb = 1'b0;
        tick;
        chk("t3_front", 32'(m_front), 1);
        chk("t3_fs", 32'(m_fs), 1);
        tick;
        chk("t3_fs_end", 32'(m_fs), 0);
        chk("t4_first_we", 32'(m_we), 1);
        chk("t4_first_addr", 32'(m_addr), 0);
        chk("t4_first_wdata", 32'(m_wdata), 0);

        // clear with interleaved reads, then reset at count 1000
        w = 1; bad = 0; acc = 0;
        for (int c = 0; c < 5000 && w < 1000; c++) begin
            req = c[0];
            #1;
            if (m_rrdy) acc++;
            tick;
            if (m_we) begin
                if (m_addr !== 20'(w) || m_wdata !== 3'd0) bad++;
                w++;
            end
        end
        chk("t6_writes", 32'(w), 1000);
        chk("t6_bad_writes", 32'(bad), 0);
        chk("t6_no_accept", 32'(acc), 0);
        #2 rst = 1'b1; req = 1'b0;
        #1;
        chk("t6_we", 32'(m_we), 0);
        chk("t6_front", 32'(m_front), 0);
        chk("t6_dvld", 32'(m_dvld), 0);
        chk("t6_rrdy", 32'(m_rrdy), 0);
        @(negedge clk) rst = 1'b0;
        #1 chk("t6_accept", 32'(m_rrdy), 1);
        tick;
        chk("t6_we_after", 32'(m_we), 1);
        chk("t6_addr_after", 32'(m_addr), 32'h80505);
        rdy = 1'b0;

        // small frame: rast_done with vblank, then a complete clear
        s_done = 1'b1; s_vb = 1'b1;
        tick;
        s_done = 1'b0;
        tick;
        chk("s_front_pre", 32'(s_front), 0);
        s_vb = 1'b0;
        tick;
        chk("s_front", 32'(s_front), 1);
        chk("s_fs", 32'(s_fs), 1);
        s_rdy = 1'b1; x = 10'd5; y = 9'd2; col = 3'd5;
        w = 0; bad = 0; acc = 0;
        for (int c = 0; c < 400 && w < 32; c++) begin
            s_req = c[0];
            #1;
            if (s_rrdy) acc++;
            tick;
            if (s_we) begin
                if (s_addr !== 20'(w) || s_wdata !== 3'd0) bad++;
                w++;
            end
        end
        chk("s_writes", 32'(w), 32);
        chk("s_bad_writes", 32'(bad), 0);
        chk("s_no_accept", 32'(acc), 0);
        s_req = 1'b0;
        #1 chk("s_resume", 32'(s_rrdy), 1);
        tick;
        chk("s_we", 32'(s_we), 1);
        chk("s_addr", 32'(s_addr), 21);
        s_rdy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
